// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
// Holds the sequencer state encoding, wait-counter width and default watchdog limit.
package arm_pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  localparam int WAIT_W       = 8;
  localparam int MAX_WAIT_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and active-low reset.
// Holds at all-ones once full.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage ARM pipeline with SRAM wait FSM.
// `PIPELINE_FORWARDING_EN restricts stalls to load-use hazards.
module pipeline_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard,
  input  logic             exe_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             sram_start,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_mem,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_set;
  logic              w_req;
  logic              w_hold;
  logic              w_freeze_all;
  logic              w_stall;

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_timeout_set = 1'b0;
    unique case (r_state)
      RUN: begin
        if (mem_req) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          w_state_nxt = RUN;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt   = RUN;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_req  = rst_n && (r_state == RUN) && mem_req;
  assign w_hold = rst_n && (r_state == MEM_WAIT) && !sram_ready;
  assign w_freeze_all = w_req || w_hold;

`ifdef PIPELINE_FORWARDING_EN
  assign w_stall = hazard && exe_mem_read;
`else
  assign w_stall = hazard;
`endif

  // Branch outranks the hazard: the stalled instruction is being discarded.
  always_comb begin
    sram_start   = w_req;
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    freeze_mem   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    if (!rst_n) begin
      sram_start = 1'b0;
    end else if (w_freeze_all) begin
      freeze_if  = 1'b1;
      freeze_id  = 1'b1;
      freeze_mem = 1'b1;
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (w_stall) begin
      freeze_if    = 1'b1;
      freeze_id    = 1'b1;
      flush_id_exe = 1'b1;
    end
  end

  assign mem_timeout = r_timeout;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (freeze_if),
    .i_clr (1'b0),
    .o_cnt (stall_cnt)
  );

endmodule
